// File: rtl/fsk.sv
// Binary FSK modulator: serializes data_in MSB-first, slow square tone for '0', fast for '1'.
// Latency: data_out is registered, one clock after the edge it reflects; no backpressure, free-running.
module fsk #(
    parameter int WIDTH      = 16,
    parameter int BIT_CYCLES = 16,
    parameter int HALF0      = 4,
    parameter int HALF1      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic             data_out
);

    localparam int KW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Frame counter kept as (slot, k) so no divider is needed on fc itself.
    logic [KW-1:0]    k;
    logic [SW-1:0]    slot;
    logic [WIDTH-1:0] word;

    logic             frame_start;
    logic             k_last;
    logic             slot_last;
    logic [SW-1:0]    bit_idx;
    logic             b;
    logic [31:0]      k32;
    logic             tone;

    always_comb begin
        frame_start = (k == '0) && (slot == '0);
        k_last      = (k == KW'(BIT_CYCLES - 1));
        slot_last   = (slot == SW'(WIDTH - 1));
        bit_idx     = SW'(WIDTH - 1) - slot;
        // The word register is not yet loaded on the capture edge, so bypass it.
        b           = frame_start ? data_in[WIDTH-1] : word[bit_idx];
        k32         = 32'(k);
        if (b) begin
            tone = ((k32 / HALF1) % 32'd2) == 32'd0;
        end else begin
            tone = ((k32 / HALF0) % 32'd2) == 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= 1'b0;
            k        <= '0;
            slot     <= '0;
            word     <= '0;
        end else begin
            data_out <= tone;
            if (frame_start) begin
                word <= data_in;
            end
            if (k_last) begin
                k    <= '0;
                slot <= slot_last ? '0 : slot + 1'b1;
            end else begin
                k    <= k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fsk.sv
// Bench for fsk: frame-level arithmetic reference model checked on every edge plus directed slot patterns.
module tb_fsk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        data_out;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: one plain frame counter, one captured word.
    int          m_fc = 0;
    logic [15:0] m_word = 16'h0000;
    logic        m_exp;
    logic        rec [256];

    fsk #(.WIDTH(16), .BIT_CYCLES(16), .HALF0(4), .HALF1(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int fc_edge;
        int h;
        logic bit_v;
        fc_edge = m_fc;
        if (rst) begin
            m_fc   = 0;
            m_word = 16'h0000;
            m_exp  = 1'b0;
        end else begin
            if (m_fc == 0) m_word = data_in;
            bit_v = m_word[15 - (m_fc / 16)];
            h     = bit_v ? 2 : 4;
            m_exp = (((m_fc % 16) / h) % 2) == 0;
            m_fc  = (m_fc + 1) % 256;
        end
        #1;
        chk("wave", {31'd0, data_out}, {31'd0, m_exp});
        if (!rst) rec[fc_edge] = data_out;
    end

    function automatic logic [15:0] slot_pat(input int s);
        logic [15:0] p;
        for (int k = 0; k < 16; k++) p[15-k] = rec[s*16 + k];
        return p;
    endfunction

    // Waits until the next edge is a capture edge, presents w, then runs a whole frame.
    task automatic next_frame(input logic [15:0] w);
        int guard;
        guard = 0;
        @(negedge clk);
        while (m_fc != 0 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 600) chk("frame_timeout", 32'd1, 32'd0);
        data_in = w;
        repeat (256) @(posedge clk);
        #2;
    endtask

    task automatic wait_fc(input int target);
        int guard;
        guard = 0;
        while (m_fc != target && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 600) chk("fc_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        int          kind;

        // Reset held for 5 clocks, then first edge must be high.
        repeat (5) @(posedge clk);
        #2 chk("rst_out", {31'd0, data_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2 chk("first_edge", {31'd0, data_out}, 32'd1);

        // All zeros: slow tone in every slot, repeated over two frames.
        for (int f = 0; f < 2; f++) begin
            next_frame(16'h0000);
            for (int s = 0; s < 16; s++) chk("zero_slot", {16'd0, slot_pat(s)}, 32'h0000F0F0);
        end

        // All ones: fast tone.
        next_frame(16'hFFFF);
        for (int s = 0; s < 16; s++) chk("ones_slot", {16'd0, slot_pat(s)}, 32'h0000CCCC);

        // 8001: fast at the edges of the frame, slow inside.
        next_frame(16'h8001);
        chk("s0",    {16'd0, slot_pat(0)},  32'h0000CCCC);
        chk("s1",    {16'd0, slot_pat(1)},  32'h0000F0F0);
        chk("s14",   {16'd0, slot_pat(14)}, 32'h0000F0F0);
        chk("s15",   {16'd0, slot_pat(15)}, 32'h0000CCCC);
        chk("b15",   {31'd0, rec[15]},  32'd0);
        chk("b16",   {31'd0, rec[16]},  32'd1);
        chk("b18",   {31'd0, rec[18]},  32'd1);
        chk("b239",  {31'd0, rec[239]}, 32'd0);
        chk("b240",  {31'd0, rec[240]}, 32'd1);
        chk("b242",  {31'd0, rec[242]}, 32'd0);

        // Mid-frame change of data_in must not affect the running frame.
        @(negedge clk);
        wait_fc(0);
        data_in = 16'h0000;
        @(negedge clk);
        wait_fc(100);
        data_in = 16'hFFFF;
        wait_fc(0);
        #1;
        for (int s = 0; s < 16; s++) chk("late_chg", {16'd0, slot_pat(s)}, 32'h0000F0F0);
        next_frame(16'hFFFF);
        for (int s = 0; s < 16; s++) chk("after_chg", {16'd0, slot_pat(s)}, 32'h0000CCCC);

        // Reset at fc=70 for two clocks, then a fresh frame from the release.
        @(negedge clk);
        wait_fc(0);
        data_in = 16'h0000;
        @(negedge clk);
        wait_fc(70);
        rst = 1'b1;
        @(posedge clk);
        #2 chk("mid_rst0", {31'd0, data_out}, 32'd0);
        @(posedge clk);
        #2 chk("mid_rst1", {31'd0, data_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        data_in = 16'hFFFF;
        repeat (256) @(posedge clk);
        #2;
        for (int s = 0; s < 16; s++) chk("post_rst", {16'd0, slot_pat(s)}, 32'h0000CCCC);

        // Random words, random mid-frame disturbances and occasional resets.
        for (int f = 0; f < 20; f++) begin
            w    = 16'($urandom);
            kind = int'($urandom_range(0, 3));
            @(negedge clk);
            wait_fc(0);
            data_in = w;
            if (kind == 1) begin
                @(negedge clk);
                wait_fc(int'($urandom_range(1, 255)));
                data_in = 16'($urandom);
            end else if (kind == 2) begin
                @(negedge clk);
                wait_fc(int'($urandom_range(1, 255)));
                rst = 1'b1;
                repeat (int'($urandom_range(1, 3))) @(negedge clk);
                rst = 1'b0;
                data_in = 16'($urandom);
            end
            repeat (300) @(posedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
